// File: rtl/jbi_out_pkg.sv
// Shared encodings for the JBus output sequencer: FSM states, source selects, default length width.
package jbi_out_pkg;

  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic SEL_PIO = 1'b0;
  localparam logic SEL_DQ  = 1'b1;

endpackage

// File: rtl/jbi_jbus_out_seq_if.sv
// Queue-head, arbiter and J_AD-datapath handshake bundle around the output sequencer.
// Perf counter outputs exist only when JBI_OUT_SEQ_PERF_EN is defined.
interface jbi_jbus_out_seq_if #(parameter int LEN_W = jbi_out_pkg::LEN_W_DEF);

  logic             pio_valid;
  logic [LEN_W-1:0] pio_len;
  logic             dq_valid;
  logic [LEN_W-1:0] dq_len;
  logic             aok_on;
  logic             dok_on;
  logic             grant;
  logic             multiple_ok;
  logic             int_req;
  logic             multiple_in_progress;
  logic             stream_break_point;
  logic             have_trans_waiting;
  logic             piorqq_req;
  logic             int_requestor_piorqq;
  logic             pio_pop;
  logic             dq_pop;
  logic             out_vld;
  logic             out_sel;
  logic             out_first;
  logic             out_last;
`ifdef JBI_OUT_SEQ_PERF_EN
  logic [31:0]      perf_beats;
  logic [31:0]      perf_req_stall;
`endif

  modport master (
`ifdef JBI_OUT_SEQ_PERF_EN
    output perf_beats, perf_req_stall,
`endif
    input  pio_valid, pio_len, dq_valid, dq_len, aok_on, dok_on, grant, multiple_ok,
    output int_req, multiple_in_progress, stream_break_point, have_trans_waiting,
           piorqq_req, int_requestor_piorqq, pio_pop, dq_pop,
           out_vld, out_sel, out_first, out_last
  );

  modport slave (
`ifdef JBI_OUT_SEQ_PERF_EN
    input  perf_beats, perf_req_stall,
`endif
    output pio_valid, pio_len, dq_valid, dq_len, aok_on, dok_on, grant, multiple_ok,
    input  int_req, multiple_in_progress, stream_break_point, have_trans_waiting,
           piorqq_req, int_requestor_piorqq, pio_pop, dq_pop,
           out_vld, out_sel, out_first, out_last
  );

endinterface

// File: rtl/jbi_out_rr2.sv
// Two-way round-robin picker: elig[0] = PIORQQ, elig[1] = DQ; combinational, no backpressure.
module jbi_out_rr2
  import jbi_out_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last_sel,
  output logic       pick,
  output logic       any
);

  assign any = |elig;

  always_comb begin
    pick = elig[1];
    if (&elig) pick = ~last_sel;
  end

endmodule

// File: rtl/jbi_jbus_out_seq.sv
// JBus output sequencer: picks PIORQQ/DQ packets, requests the arbiter, strobes one beat per cycle.
// Beats issue in the grant/multiple_ok cycle; optional perf counters under JBI_OUT_SEQ_PERF_EN.
module jbi_jbus_out_seq
  import jbi_out_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_l,
  jbi_jbus_out_seq_if.master    bus
);

  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  state_t           state;
  logic             cur_sel;
  logic             last_sel;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] cnt;

  logic             pio_elig, dq_elig;
  logic             pick, any, rr_last;
  logic [LEN_W-1:0] next_len;
  logic             in_req, in_send;
  logic             issue_single, issue_multi, send_last;
  logic             beat, pkt_end, load;

  assign pio_elig = bus.pio_valid && bus.aok_on;
  assign dq_elig  = bus.dq_valid && bus.dok_on;

  // At a packet boundary the packet just finished counts as the most recent winner.
  assign rr_last = pkt_end ? cur_sel : last_sel;

  jbi_out_rr2 u_rr (
    .elig     ({dq_elig, pio_elig}),
    .last_sel (rr_last),
    .pick     (pick),
    .any      (any)
  );

  assign next_len     = pick ? bus.dq_len : bus.pio_len;
  assign in_req       = (state == REQ);
  assign in_send      = (state == SEND);
  assign issue_single = in_req && (cur_len == LEN_ONE) && bus.grant;
  assign issue_multi  = in_req && (cur_len > LEN_ONE) && bus.multiple_ok;
  assign send_last    = in_send && (cnt == LEN_ONE);
  assign beat         = issue_single || issue_multi || in_send;
  assign pkt_end      = issue_single || send_last;
  assign load         = ((state == IDLE) || pkt_end) && any;

  assign bus.int_req              = in_req || in_send;
  assign bus.multiple_in_progress = in_send || issue_multi;
  assign bus.stream_break_point   = pkt_end;
  assign bus.have_trans_waiting   = pio_elig || dq_elig || (state != IDLE);
  assign bus.piorqq_req           = bus.pio_valid;
  assign bus.int_requestor_piorqq = (in_req || in_send) && (cur_sel == SEL_PIO);
  assign bus.out_vld              = beat;
  assign bus.out_sel              = cur_sel;
  assign bus.out_first            = issue_single || issue_multi;
  assign bus.out_last             = pkt_end;
  assign bus.pio_pop              = beat && (cur_sel == SEL_PIO);
  assign bus.dq_pop               = beat && (cur_sel == SEL_DQ);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state    <= IDLE;
      cur_sel  <= SEL_PIO;
      last_sel <= SEL_DQ;
      cur_len  <= '0;
      cnt      <= '0;
    end else begin
      if (load) begin
        cur_sel <= pick;
        cur_len <= next_len;
      end
      if (pkt_end) last_sel <= cur_sel;
      case (state)
        IDLE: if (any) state <= REQ;
        // A latched head is committed: losing aok/dok here does not abandon it.
        REQ: begin
          if (issue_multi) begin
            cnt   <= cur_len - LEN_ONE;
            state <= SEND;
          end else if (issue_single) begin
            state <= any ? REQ : IDLE;
          end
        end
        SEND: begin
          cnt <= cnt - LEN_ONE;
          if (send_last) state <= any ? REQ : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JBI_OUT_SEQ_PERF_EN
  logic [31:0] perf_beats_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      perf_beats_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (beat && !(&perf_beats_q)) perf_beats_q <= perf_beats_q + 32'd1;
      if (in_req && !issue_single && !issue_multi && !(&perf_stall_q))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_beats     = perf_beats_q;
  assign bus.perf_req_stall = perf_stall_q;
`endif

  a_len_nonzero: assert property (@(posedge clk) disable iff (!rst_l) load |-> (next_len != '0));

endmodule

// File: tb/tb_jbi_jbus_out_seq.sv
// Directed bench for jbi_jbus_out_seq: expected beats queued by stimulus, checked by a negedge monitor.
// Perf counter checks run when JBI_OUT_SEQ_PERF_EN is defined.
module tb_jbi_jbus_out_seq;
  import jbi_out_pkg::*;

  typedef struct packed {
    logic sel;
    logic first;
    logic last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_l;
  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  jbi_jbus_out_seq_if bus ();

  jbi_jbus_out_seq dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic first, input logic last);
    beat_t b;
    b.sel = sel;
    b.first = first;
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Beat monitor: every out_vld must match the next queued beat, pops must follow it.
  always @(negedge clk) begin
    if (rst_l === 1'b1) begin
      if (bus.out_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got sel=%0b first=%0b last=%0b, none expected",
                   bus.out_sel, bus.out_first, bus.out_last);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat", {29'd0, bus.out_sel, bus.out_first, bus.out_last}, {29'd0, e});
          chk("beat_pops", {30'd0, bus.pio_pop, bus.dq_pop}, e.sel ? 32'd1 : 32'd2);
        end
      end else begin
        chk("idle_pops", {30'd0, bus.pio_pop, bus.dq_pop}, 32'd0);
      end
    end
  end

  initial begin
    rst_l = 1'b0;
    bus.pio_valid = 0; bus.pio_len = '0; bus.dq_valid = 0; bus.dq_len = '0;
    bus.aok_on = 0; bus.dok_on = 0; bus.grant = 0; bus.multiple_ok = 0;
    repeat (3) cyc();
    rst_l = 1'b1;
    @(negedge clk);
    chk("rst_int_req", bus.int_req, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_htw", bus.have_trans_waiting, 0);
    chk("rst_piorqq_req", bus.piorqq_req, 0);
    chk("rst_mip", bus.multiple_in_progress, 0);
    chk("rst_sbp", bus.stream_break_point, 0);

    // Single-beat PIO, grant one cycle late
    cyc();
    bus.pio_valid = 1; bus.pio_len = 4'd1; bus.aok_on = 1;
    @(negedge clk);
    chk("t1_idle_int_req", bus.int_req, 0);
    chk("t1_htw", bus.have_trans_waiting, 1);
    cyc();
    bus.pio_valid = 0;
    @(negedge clk);
    chk("t1_int_req", bus.int_req, 1);
    chk("t1_no_beat", bus.out_vld, 0);
    chk("t1_requestor", bus.int_requestor_piorqq, 1);
    cyc();
    bus.grant = 1;
    push(SEL_PIO, 1, 1);
    @(negedge clk);
    chk("t1_sbp", bus.stream_break_point, 1);
    cyc();
    bus.grant = 0;
    @(negedge clk);
    chk("t1_back_idle", bus.int_req, 0);
    chk("t1_htw_idle", bus.have_trans_waiting, 0);

    // 4-beat DQ: grant alone must not start it, multiple_ok does
    cyc();
    bus.dq_valid = 1; bus.dq_len = 4'd4; bus.dok_on = 1; bus.grant = 1;
    cyc();
    bus.dq_valid = 0;
    @(negedge clk);
    chk("t2_int_req", bus.int_req, 1);
    chk("t2_stall0", bus.out_vld, 0);
    for (int s = 1; s < 3; s++) begin
      cyc();
      @(negedge clk);
      chk("t2_stall", bus.out_vld, 0);
    end
    cyc();
    bus.multiple_ok = 1;
    push(SEL_DQ, 1, 0); push(SEL_DQ, 0, 0); push(SEL_DQ, 0, 0); push(SEL_DQ, 0, 1);
    @(negedge clk);
    chk("t2_mip_first", bus.multiple_in_progress, 1);
    chk("t2_sbp_first", bus.stream_break_point, 0);
    for (int k = 1; k < 4; k++) begin
      cyc();
      bus.multiple_ok = 0;
      @(negedge clk);
      chk("t2_mip", bus.multiple_in_progress, 1);
      chk("t2_int_req_send", bus.int_req, 1);
      chk("t2_sbp", bus.stream_break_point, (k == 3) ? 32'd1 : 32'd0);
    end
    cyc();
    bus.grant = 0;
    @(negedge clk);
    chk("t2_back_idle", bus.int_req, 0);

    // Both queues valid, 2-beat packets: strict alternation starting with PIO
    bus.pio_valid = 1; bus.pio_len = 4'd2; bus.dq_valid = 1; bus.dq_len = 4'd2;
    bus.grant = 1; bus.multiple_ok = 1;
    cyc();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) cyc();
      if (c == 5) begin
        bus.pio_valid = 0; bus.dq_valid = 0;
      end
      push(((c / 2) % 2) == 1, (c % 2) == 0, (c % 2) == 1);
      @(negedge clk);
      chk("t3_int_req", bus.int_req, 1);
      chk("t3_sbp", bus.stream_break_point, c % 2);
    end
    cyc();
    bus.grant = 0; bus.multiple_ok = 0;
    @(negedge clk);
    chk("t3_back_idle", bus.int_req, 0);

    // AOK gating
    bus.pio_valid = 1; bus.pio_len = 4'd1; bus.aok_on = 0;
    @(negedge clk);
    chk("t4_int_req", bus.int_req, 0);
    chk("t4_htw", bus.have_trans_waiting, 0);
    chk("t4_piorqq_req", bus.piorqq_req, 1);
    cyc();
    @(negedge clk);
    chk("t4_still_idle", bus.int_req, 0);
    cyc();
    bus.aok_on = 1;
    cyc();
    bus.pio_valid = 0; bus.grant = 1;
    push(SEL_PIO, 1, 1);
    @(negedge clk);
    chk("t4_req", bus.int_req, 1);
    chk("t4_requestor", bus.int_requestor_piorqq, 1);
    cyc();
    bus.grant = 0;
    @(negedge clk);
    chk("t4_back_idle", bus.int_req, 0);

    // Reset in the 2nd beat of a 4-beat DQ packet
    bus.dq_valid = 1; bus.dq_len = 4'd4; bus.dok_on = 1; bus.grant = 1; bus.multiple_ok = 1;
    cyc();
    bus.dq_valid = 0;
    push(SEL_DQ, 1, 0);
    @(negedge clk);
    chk("t5_mip", bus.multiple_in_progress, 1);
    cyc();
    rst_l = 0;
    cyc();
    rst_l = 1;
    bus.pio_valid = 1; bus.pio_len = 4'd1; bus.dq_valid = 1; bus.dq_len = 4'd1;
    @(negedge clk);
    chk("t5_rst_int_req", bus.int_req, 0);
    chk("t5_rst_out_vld", bus.out_vld, 0);
    chk("t5_rst_dq_pop", bus.dq_pop, 0);
    chk("t5_rst_mip", bus.multiple_in_progress, 0);
    cyc();
    bus.pio_valid = 0;
    push(SEL_PIO, 1, 1);
    @(negedge clk);
    chk("t5_prefers_pio", bus.int_requestor_piorqq, 1);
    cyc();
    bus.dq_valid = 0;
    push(SEL_DQ, 1, 1);
    @(negedge clk);
    chk("t5_b2b_int_req", bus.int_req, 1);
    chk("t5_dq_requestor", bus.int_requestor_piorqq, 0);
    cyc();
    bus.grant = 0; bus.multiple_ok = 0;
    @(negedge clk);
    chk("t5_back_idle", bus.int_req, 0);

`ifdef JBI_OUT_SEQ_PERF_EN
    rst_l = 0;
    cyc();
    rst_l = 1;
    @(negedge clk);
    chk("perf_beats_rst", bus.perf_beats, 0);
    chk("perf_stall_rst", bus.perf_req_stall, 0);
    bus.pio_valid = 1; bus.pio_len = 4'd4; bus.aok_on = 1; bus.grant = 1; bus.multiple_ok = 0;
    cyc();
    cyc();
    cyc();
    bus.multiple_ok = 1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cyc();
      if (i == 11) bus.pio_valid = 0;
      push(SEL_PIO, (i % 4) == 0, (i % 4) == 3);
      @(negedge clk);
    end
    cyc();
    bus.grant = 0; bus.multiple_ok = 0;
    @(negedge clk);
    chk("perf_beats", bus.perf_beats, 12);
    chk("perf_req_stall", bus.perf_req_stall, 2);
`endif

    cyc();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
